// File: rtl/display_timings_rx.sv
// display_timings_rx: recovers active x/y, measures line/frame geometry from hsync/vsync/de and asserts locked once the geometry repeats.
// Latency: inputs registered once; de_o/sx/sy, pulses and status all appear 1 clk_pix after the input cycle that causes them.
// Backpressure: none; the video stream is free-running and every pixel clock is consumed.
//
// Ports:
//   clk_pix, rst_n           pixel clock, asynchronous active-low reset
//   hsync, vsync, de         incoming timing (sync polarity set by H_POL / V_POL, 0 = active low)
//   de_o, sx, sy             de and recovered active coordinates, aligned with each other
//   frame_start, line_start  one-cycle pulses on vsync / hsync leading edges
//   h_total, h_active,       candidate geometry: clocks per line, de clocks per active line,
//   v_total, v_active        lines per frame, active lines per frame
//   locked, err              geometry stable / one-cycle pulse on a geometry mismatch
//   err_count, frame_count   statistics, built only when DISPLAY_TIMINGS_RX_STATS_EN is defined;
//                            otherwise both are tied to 0
module display_timings_rx #(
    parameter int CORDW       = 10,
    parameter bit H_POL       = 1'b0,
    parameter bit V_POL       = 1'b0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk_pix,
    input  logic             rst_n,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             de,
    output logic             de_o,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             frame_start,
    output logic             line_start,
    output logic [CORDW-1:0] h_total,
    output logic [CORDW-1:0] h_active,
    output logic [CORDW-1:0] v_total,
    output logic [CORDW-1:0] v_active,
    output logic             locked,
    output logic             err,
    output logic [15:0]      err_count,
    output logic [15:0]      frame_count
);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_VERIFY  = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    localparam logic [CORDW-1:0] CNT_SAT  = '1;
    localparam logic [CORDW-1:0] CNT_ONE  = CORDW'(1);
    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_FRAMES);

    function automatic logic [CORDW-1:0] sat_inc(input logic [CORDW-1:0] v);
        return (v == CNT_SAT) ? v : v + CNT_ONE;
    endfunction

    // ------------------------------------------------------------------
    // Input stage: syncs normalised to active-high, one register stage
    // ------------------------------------------------------------------
    logic hs_act, vs_act;
    logic hs_q, vs_q, de_q;
    logic hs_edge, vs_edge, de_rise;

    assign hs_act  = (hsync == H_POL);
    assign vs_act  = (vsync == V_POL);
    assign hs_edge = hs_act & ~hs_q;
    assign vs_edge = vs_act & ~vs_q;
    assign de_rise = de & ~de_q;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [3:0]       match_q, match_d;

    logic [CORDW-1:0] line_cnt_q, line_cnt_d;
    logic [CORDW-1:0] act_cnt_q, act_cnt_d;
    logic [CORDW-1:0] last_h_q, last_h_d;
    logic [CORDW-1:0] last_ha_q, last_ha_d;
    logic [CORDW-1:0] vline_cnt_q, vline_cnt_d;
    logic [CORDW-1:0] vact_cnt_q, vact_cnt_d;

    logic [CORDW-1:0] h_total_q, h_total_d;
    logic [CORDW-1:0] h_active_q, h_active_d;
    logic [CORDW-1:0] v_total_q, v_total_d;
    logic [CORDW-1:0] v_active_q, v_active_d;

    logic [CORDW-1:0] sx_q, sx_d;
    logic [CORDW-1:0] sy_q, sy_d;
    logic             first_q, first_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             de_o_q, frame_start_q, line_start_q;

    // ------------------------------------------------------------------
    // Line / frame measurement
    // ------------------------------------------------------------------
    // An hsync interval spans the tail of one line and the head of the next,
    // so its de count is the active width of a visible line and 0 in blanking.
    // Only intervals that contained de take part in h_active.
    logic             line_has_de;
    logic [CORDW-1:0] h_cl, ha_cl, v_cl, va_cl;
    logic             line_bad, frame_bad;

    assign line_has_de = (act_cnt_q != '0);

    // Values of the frame being closed; a coincident hsync edge closes its
    // line first, so that line is included.
    assign h_cl  = hs_edge ? line_cnt_q : last_h_q;
    assign ha_cl = (hs_edge && line_has_de) ? act_cnt_q : last_ha_q;
    assign v_cl  = hs_edge ? sat_inc(vline_cnt_q) : vline_cnt_q;
    assign va_cl = vact_cnt_q;

    // A saturated count means the period overflowed and is never a match.
    assign line_bad  = (line_cnt_q != h_total_q) || (line_cnt_q == CNT_SAT) ||
                       (line_has_de && ((act_cnt_q != h_active_q) || (act_cnt_q == CNT_SAT)));

    assign frame_bad = (h_cl  != h_total_q)  || (h_cl  == CNT_SAT) ||
                       (ha_cl != h_active_q) || (ha_cl == CNT_SAT) ||
                       (v_cl  != v_total_q)  || (v_cl  == CNT_SAT) ||
                       (va_cl != v_active_q) || (va_cl == CNT_SAT);

    always_comb begin
        line_cnt_d  = sat_inc(line_cnt_q);
        act_cnt_d   = de ? sat_inc(act_cnt_q) : act_cnt_q;
        last_h_d    = last_h_q;
        last_ha_d   = last_ha_q;
        vline_cnt_d = hs_edge ? sat_inc(vline_cnt_q) : vline_cnt_q;
        vact_cnt_d  = de_rise ? sat_inc(vact_cnt_q) : vact_cnt_q;

        // The edge cycle itself is the first clock of the new line.
        if (hs_edge) begin
            line_cnt_d = CNT_ONE;
            act_cnt_d  = de ? CNT_ONE : '0;
            last_h_d   = line_cnt_q;
            if (line_has_de) begin
                last_ha_d = act_cnt_q;
            end
        end

        // A de rise coincident with the vsync edge belongs to the new frame.
        if (vs_edge) begin
            vline_cnt_d = '0;
            vact_cnt_d  = de_rise ? CNT_ONE : '0;
        end
    end

    // ------------------------------------------------------------------
    // Coordinates
    // ------------------------------------------------------------------
    always_comb begin
        sx_d    = sx_q;
        sy_d    = sy_q;
        first_d = first_q;

        if (de) begin
            sx_d = de_q ? sx_q + CNT_ONE : '0;
        end

        if (de_rise) begin
            sy_d    = (first_q || vs_edge) ? '0 : sy_q + CNT_ONE;
            first_d = 1'b0;
        end else if (vs_edge) begin
            first_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Lock FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        match_d    = match_q;
        err_d      = 1'b0;
        h_total_d  = h_total_q;
        h_active_d = h_active_q;
        v_total_d  = v_total_q;
        v_active_d = v_active_q;

        case (state_q)
            ST_SEARCH: begin
                if (vs_edge) begin
                    state_d = ST_MEASURE;
                end
            end

            ST_MEASURE: begin
                if (vs_edge) begin
                    h_total_d  = h_cl;
                    h_active_d = ha_cl;
                    v_total_d  = v_cl;
                    v_active_d = va_cl;
                    match_d    = '0;
                    state_d    = ST_VERIFY;
                end
            end

            ST_VERIFY: begin
                if (hs_edge && line_bad) begin
                    // A bad line invalidates the current frame too; remeasure.
                    err_d   = 1'b1;
                    match_d = '0;
                    state_d = ST_MEASURE;
                end else if (vs_edge) begin
                    if (frame_bad) begin
                        err_d      = 1'b1;
                        h_total_d  = h_cl;
                        h_active_d = ha_cl;
                        v_total_d  = v_cl;
                        v_active_d = va_cl;
                        match_d    = '0;
                    end else if (match_q + 4'd1 >= LOCK_TGT) begin
                        match_d = '0;
                        state_d = ST_LOCKED;
                    end else begin
                        match_d = match_q + 4'd1;
                    end
                end
            end

            ST_LOCKED: begin
                if ((hs_edge && line_bad) || (vs_edge && frame_bad)) begin
                    err_d   = 1'b1;
                    match_d = '0;
                    state_d = ST_MEASURE;
                end
            end

            default: begin
                state_d = ST_SEARCH;
            end
        endcase

        locked_d = (state_d == ST_LOCKED);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            de_q          <= 1'b0;
            state_q       <= ST_SEARCH;
            match_q       <= '0;
            line_cnt_q    <= '0;
            act_cnt_q     <= '0;
            last_h_q      <= '0;
            last_ha_q     <= '0;
            vline_cnt_q   <= '0;
            vact_cnt_q    <= '0;
            h_total_q     <= '0;
            h_active_q    <= '0;
            v_total_q     <= '0;
            v_active_q    <= '0;
            sx_q          <= '0;
            sy_q          <= '0;
            first_q       <= 1'b1;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
            de_o_q        <= 1'b0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            hs_q          <= hs_act;
            vs_q          <= vs_act;
            de_q          <= de;
            state_q       <= state_d;
            match_q       <= match_d;
            line_cnt_q    <= line_cnt_d;
            act_cnt_q     <= act_cnt_d;
            last_h_q      <= last_h_d;
            last_ha_q     <= last_ha_d;
            vline_cnt_q   <= vline_cnt_d;
            vact_cnt_q    <= vact_cnt_d;
            h_total_q     <= h_total_d;
            h_active_q    <= h_active_d;
            v_total_q     <= v_total_d;
            v_active_q    <= v_active_d;
            sx_q          <= sx_d;
            sy_q          <= sy_d;
            first_q       <= first_d;
            locked_q      <= locked_d;
            err_q         <= err_d;
            de_o_q        <= de;
            frame_start_q <= vs_edge;
            line_start_q  <= hs_edge;
        end
    end

    assign de_o        = de_o_q;
    assign sx          = sx_q;
    assign sy          = sy_q;
    assign frame_start = frame_start_q;
    assign line_start  = line_start_q;
    assign h_total     = h_total_q;
    assign h_active    = h_active_q;
    assign v_total     = v_total_q;
    assign v_active    = v_active_q;
    assign locked      = locked_q;
    assign err         = err_q;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef DISPLAY_TIMINGS_RX_STATS_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        err_cnt_d   = err_cnt_q;
        frame_cnt_d = frame_cnt_q;
        // Counted alongside err so both outputs move in the same cycle.
        if (err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
        if (vs_edge) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            err_cnt_q   <= err_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign err_count   = err_cnt_q;
    assign frame_count = frame_cnt_q;
`else
    assign err_count   = '0;
    assign frame_count = '0;
`endif

endmodule
